// File: rtl/instruction_fetch.sv
// Instruction fetch stage: keeps one request outstanding to instruction memory, buffers a word
// that arrives while decode is stalled, and squashes an in-flight word after a taken branch.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        branch_in,
  input  logic [31:0] target_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_ready_in,
  input  logic [31:0] imem_data_in,
  output logic [31:0] IR_out,
  output logic [31:0] PC_out,
  output logic        IR_valid_out
);

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_SQUASH} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_active;
  logic [31:0] r_pc;
  logic [31:0] r_buf;
  logic [31:0] r_pend;
  logic [31:0] r_ir;
  logic [31:0] r_pc_out;
  logic        r_vld;
  logic        w_req;
  logic        w_done;
  logic [31:0] w_tgt;

  assign w_tgt  = target_in & ~32'h3;
  assign w_done = w_req & imem_ready_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: begin
        // A branch against an unfinished request must wait for that request to drain
        if (branch_in)                  w_next = (w_req && !imem_ready_in) ? S_SQUASH : S_FETCH;
        else if (stall_in && w_done)    w_next = S_HOLD;
      end
      S_HOLD:   if (branch_in || !stall_in) w_next = S_FETCH;
      S_SQUASH: if (w_done) w_next = S_FETCH;
      default:  w_next = S_FETCH;
    endcase
  end

  // r_active keeps the request low until the first edge after reset is released
  always_comb begin
    w_req = r_active && (r_state != S_HOLD);
  end

  assign imem_req_out  = w_req;
  assign imem_addr_out = r_pc;
  assign IR_out        = r_ir;
  assign PC_out        = r_pc_out;
  assign IR_valid_out  = r_vld;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_active <= 1'b0;
      r_pc     <= RESET_PC;
      r_buf    <= 32'h0;
      r_pend   <= 32'h0;
      r_ir     <= 32'h0;
      r_pc_out <= 32'h0;
      r_vld    <= 1'b0;
    end else begin
      r_active <= 1'b1;
      case (r_state)
        S_FETCH: begin
          if (branch_in) begin
            r_ir  <= 32'h0;
            r_vld <= 1'b0;
            r_buf <= 32'h0;
            if (w_req && !imem_ready_in) r_pend <= w_tgt;
            else                         r_pc   <= w_tgt;
          end else if (stall_in) begin
            if (w_done) begin
              r_buf <= imem_data_in;
              r_pc  <= r_pc + 32'd4;
            end
          end else if (w_done) begin
            r_ir     <= imem_data_in;
            r_pc_out <= r_pc;
            r_vld    <= 1'b1;
            r_pc     <= r_pc + 32'd4;
          end else begin
            r_ir  <= 32'h0;
            r_vld <= 1'b0;
          end
        end
        S_HOLD: begin
          if (branch_in) begin
            r_ir  <= 32'h0;
            r_vld <= 1'b0;
            r_buf <= 32'h0;
            r_pc  <= w_tgt;
          end else if (!stall_in) begin
            // PC already advanced past the buffered word when it was captured
            r_ir     <= r_buf;
            r_pc_out <= r_pc - 32'd4;
            r_vld    <= 1'b1;
          end
        end
        S_SQUASH: begin
          r_ir  <= 32'h0;
          r_vld <= 1'b0;
          if (branch_in) r_pend <= w_tgt;
          if (w_done)    r_pc   <= branch_in ? w_tgt : r_pend;
        end
        default: begin
          r_ir  <= 32'h0;
          r_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed-vector bench for instruction_fetch: table of per-cycle inputs and expected outputs,
// plus a hand-written asynchronous reset pulse during SQUASH.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_in = 1'b0;
  logic        branch_in = 1'b0;
  logic [31:0] target_in = 32'h0;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_ready_in = 1'b0;
  logic [31:0] imem_data_in = 32'h0;
  logic [31:0] IR_out;
  logic [31:0] PC_out;
  logic        IR_valid_out;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic        stall;
    logic        branch;
    logic [31:0] target;
    logic        ready;
    logic [31:0] data;
    logic        req;
    logic [31:0] addr;
    logic [31:0] ir;
    logic [31:0] pc;
    logic        vld;
  } vec_t;

  vec_t vecs[$];

  instruction_fetch dut (
    .clk          (clk),
    .reset        (reset),
    .stall_in     (stall_in),
    .branch_in    (branch_in),
    .target_in    (target_in),
    .imem_req_out (imem_req_out),
    .imem_addr_out(imem_addr_out),
    .imem_ready_in(imem_ready_in),
    .imem_data_in (imem_data_in),
    .IR_out       (IR_out),
    .PC_out       (PC_out),
    .IR_valid_out (IR_valid_out)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic s, logic b, logic [31:0] t, logic r, logic [31:0] d,
                              logic eq, logic [31:0] ea, logic [31:0] ei, logic [31:0] ep,
                              logic ev);
    vec_t v;
    v.stall = s; v.branch = b; v.target = t; v.ready = r; v.data = d;
    v.req = eq; v.addr = ea; v.ir = ei; v.pc = ep; v.vld = ev;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_outs(input int idx, input logic req, input logic [31:0] addr,
                          input logic [31:0] ir, input logic [31:0] pc, input logic vld);
    n_vec++;
    chk("req",  idx, {31'b0, imem_req_out}, {31'b0, req});
    chk("addr", idx, imem_addr_out, addr);
    chk("ir",   idx, IR_out, ir);
    chk("pc",   idx, PC_out, pc);
    chk("vld",  idx, {31'b0, IR_valid_out}, {31'b0, vld});
  endtask

  task automatic apply(input int idx, input vec_t v);
    stall_in      = v.stall;
    branch_in     = v.branch;
    target_in     = v.target;
    imem_ready_in = v.ready;
    imem_data_in  = v.data;
    @(posedge clk);
    #1;
    chk_outs(idx, v.req, v.addr, v.ir, v.pc, v.vld);
  endtask

  initial begin
    //           stall branch target        rdy data          req addr          ir            pc            vld
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0000, 32'h0,        32'h0,        0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'hE000_0000, 1, 32'h0000_0004, 32'hE000_0000, 32'h0,       1));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'hE000_0004, 1, 32'h0000_0008, 32'hE000_0004, 32'h4,       1));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'hE000_0008, 0, 32'h0000_000C, 32'hE000_0004, 32'h4,       1));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h0000_0BAD, 0, 32'h0000_000C, 32'hE000_0004, 32'h4,       1));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h0000_0BAD, 0, 32'h0000_000C, 32'hE000_0004, 32'h4,       1));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h0000_0BAD, 1, 32'h0000_000C, 32'hE000_0008, 32'h8,       1));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'hE000_000C, 1, 32'h0000_0010, 32'hE000_000C, 32'hC,       1));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'hE000_0010, 1, 32'h0000_0014, 32'hE000_0010, 32'h10,      1));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'hE000_0014, 1, 32'h0000_0018, 32'hE000_0014, 32'h14,      1));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'hE000_0018, 1, 32'h0000_001C, 32'hE000_0018, 32'h18,      1));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'hE000_001C, 1, 32'h0000_0020, 32'hE000_001C, 32'h1C,      1));
    // squash: branch to 0x100 while 0x20 is outstanding
    vecs.push_back(mk(0, 1, 32'h100,      0, 32'h0,        1, 32'h0000_0020, 32'h0,        32'h1C,       0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0020, 32'h0,        32'h1C,       0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'hE000_0020, 1, 32'h0000_0100, 32'h0,        32'h1C,       0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h1111_1111, 1, 32'h0000_0104, 32'h1111_1111, 32'h100,     1));
    // branch together with stall, misaligned target
    vecs.push_back(mk(1, 1, 32'h43,       1, 32'h0000_2222, 1, 32'h0000_0040, 32'h0,        32'h100,      0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h3333_3333, 1, 32'h0000_0044, 32'h3333_3333, 32'h40,      1));
    // wrap at top of address space
    vecs.push_back(mk(0, 1, 32'hFFFF_FFFE, 0, 32'h0,       1, 32'h0000_0044, 32'h0,        32'h40,       0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h7777_7777, 1, 32'hFFFF_FFFC, 32'h0,        32'h40,       0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h4444_4444, 1, 32'h0000_0000, 32'h4444_4444, 32'hFFFF_FFFC, 1));
    // branch while holding a buffered word
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h5555_5555, 0, 32'h0000_0004, 32'h4444_4444, 32'hFFFF_FFFC, 1));
    vecs.push_back(mk(1, 1, 32'h200,      0, 32'h0,        1, 32'h0000_0200, 32'h0,        32'hFFFF_FFFC, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_0200, 32'h0,        32'hFFFF_FFFC, 0));
    // repeated branches in SQUASH overwrite the pending target
    vecs.push_back(mk(0, 1, 32'h300,      0, 32'h0,        1, 32'h0000_0200, 32'h0,        32'hFFFF_FFFC, 0));
    vecs.push_back(mk(0, 1, 32'h404,      0, 32'h0,        1, 32'h0000_0200, 32'h0,        32'hFFFF_FFFC, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h8888_8888, 1, 32'h0000_0404, 32'h0,        32'hFFFF_FFFC, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h9999_9999, 1, 32'h0000_0408, 32'h9999_9999, 32'h404,     1));
    vecs.push_back(mk(0, 1, 32'h500,      0, 32'h0,        1, 32'h0000_0408, 32'h0,        32'h404,      0));

    repeat (2) @(posedge clk);
    #1;
    chk_outs(-1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

    // asynchronous reset pulse between edges while in SQUASH
    branch_in     = 1'b0;
    imem_ready_in = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk_outs(100, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_outs(101, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
    imem_ready_in = 1'b1;
    imem_data_in  = 32'h6666_6666;
    @(posedge clk);
    #1;
    chk_outs(102, 1'b1, 32'h4, 32'h6666_6666, 32'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
